// File: rtl/game_pkg.sv
// game_pkg: shared phase encoding and field widths for the game round sequencer.
package game_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHOW   = 3'd1,
        ANSWER = 3'd2,
        RESULT = 3'd3,
        OVER   = 3'd4
    } phase_e;
    localparam int SEC_W   = 8;
    localparam int ROUND_W = 4;
    localparam int SCORE_W = 4;
endpackage

// File: rtl/sec_down_counter.sv
// sec_down_counter: loadable seconds counter decremented by tick, with a registered expiry flag.
module sec_down_counter
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    input  logic             tick,
    output logic [SEC_W-1:0] value,
    output logic             last
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            last  <= 1'b0;
        end else if (load) begin
            value <= load_val;
            last  <= 1'b0;
        end else begin
            last  <= tick && value == SEC_W'(1);
            value <= (tick && value != '0) ? value - SEC_W'(1) : value;
        end
    end
endmodule

// File: rtl/game_round_sequencer.sv
// game_round_sequencer: runs timed show/answer/result rounds, judges answers and keeps score.
module game_round_sequencer
    import game_pkg::*;
#(
    parameter int PERIOD_SEC = 15,
    parameter int ANSWER_SEC = 10,
    parameter int RESULT_SEC = 2,
    parameter int NUM_ROUNDS = 5,
    parameter int CNT_W      = 8
) (
    input  logic               Clk100M,
    input  logic               RstN,
    input  logic               tick1Hz,
    input  logic               gameSig,
    input  logic [CNT_W-1:0]   symCount,
    input  logic               answerValid,
    input  logic [CNT_W-1:0]   answer,
    output logic               startGen,
    output logic               stopGen,
    output logic               answerSig,
    output logic               correct,
    output logic               wrong,
    output logic [2:0]         phase,
    output logic [7:0]         timeLeft,
    output logic [ROUND_W-1:0] roundNum,
    output logic [SCORE_W-1:0] score,
    output logic               gameOver
);
    phase_e           state;
    logic             game_q;
    logic [CNT_W-1:0] exp_count;
    logic [SEC_W-1:0] time_left;
    logic [SEC_W-1:0] load_val;
    logic             last, load, start_fire, judged, hit, expire;

    assign phase    = state;
    assign timeLeft = time_left;

    // The counter reloads on phase entry; after an expiry that is the cycle following 'last'.
    always_comb begin
        start_fire = gameSig && !game_q && (state == IDLE || state == OVER);
        judged     = state == ANSWER && answerValid;
        hit        = answer == (stopGen ? symCount : exp_count);
        expire     = tick1Hz && time_left == SEC_W'(1);
        load       = start_fire || judged || last;
        load_val   = start_fire      ? SEC_W'(PERIOD_SEC) :
                     judged          ? SEC_W'(RESULT_SEC) :
                     state == SHOW   ? SEC_W'(PERIOD_SEC) :
                     state == ANSWER ? SEC_W'(ANSWER_SEC) :
                     state == RESULT ? SEC_W'(RESULT_SEC) : '0;
    end

    sec_down_counter u_timer (
        .clk      (Clk100M),
        .rst_n    (RstN),
        .load     (load),
        .load_val (load_val),
        .tick     (tick1Hz),
        .value    (time_left),
        .last     (last)
    );

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            state     <= IDLE;
            game_q    <= 1'b1;
            exp_count <= '0;
            startGen  <= 1'b0;
            stopGen   <= 1'b0;
            answerSig <= 1'b0;
            correct   <= 1'b0;
            wrong     <= 1'b0;
            roundNum  <= '0;
            score     <= '0;
            gameOver  <= 1'b0;
        end else begin
            game_q   <= gameSig;
            startGen <= 1'b0;
            stopGen  <= 1'b0;
            correct  <= 1'b0;
            wrong    <= 1'b0;
            // stopGen is high exactly on the first ANSWER cycle, when symCount has settled
            if (stopGen)
                exp_count <= symCount;
            case (state)
                IDLE, OVER: if (start_fire) begin
                    state    <= SHOW;
                    startGen <= 1'b1;
                    score    <= '0;
                    roundNum <= ROUND_W'(1);
                    gameOver <= 1'b0;
                end
                SHOW: if (expire) begin
                    state     <= ANSWER;
                    stopGen   <= 1'b1;
                    answerSig <= 1'b1;
                end
                ANSWER: if (judged || expire) begin
                    state     <= RESULT;
                    answerSig <= 1'b0;
                    correct   <= judged && hit;
                    wrong     <= !(judged && hit);
                    if (judged && hit && score != '1)
                        score <= score + SCORE_W'(1);
                end
                RESULT: if (expire) begin
                    if (roundNum == ROUND_W'(NUM_ROUNDS)) begin
                        state    <= OVER;
                        gameOver <= 1'b1;
                    end else begin
                        state    <= SHOW;
                        roundNum <= roundNum + ROUND_W'(1);
                        startGen <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_round_sequencer.sv
// tb_game_round_sequencer: directed and random stimulus checked against a behavioural game model.
module tb_game_round_sequencer;
    localparam int P = 15, A = 10, R = 2, N = 2;

    logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, gs = 1'b1, av = 1'b0;
    logic [7:0] sym = '0, ans = '0;
    logic       start_gen, stop_gen, answer_sig, correct, wrong, game_over;
    logic [2:0] phase;
    logic [7:0] time_left;
    logic [3:0] round_num, score;

    game_round_sequencer #(.PERIOD_SEC(P), .ANSWER_SEC(A), .RESULT_SEC(R), .NUM_ROUNDS(N), .CNT_W(8)) dut (
        .Clk100M(clk), .RstN(rst_n), .tick1Hz(tick), .gameSig(gs), .symCount(sym),
        .answerValid(av), .answer(ans), .startGen(start_gen), .stopGen(stop_gen),
        .answerSig(answer_sig), .correct(correct), .wrong(wrong), .phase(phase),
        .timeLeft(time_left), .roundNum(round_num), .score(score), .gameOver(game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    // model: phase 0..4, seconds left, pending reload (-1 none), round, score, expected count
    int m_ph, m_tl, m_pend, m_rnd, m_sc, m_exp;
    bit m_gq, m_sg, m_st, m_ok, m_bad, m_go;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ph = 0; m_tl = 0; m_pend = -1; m_rnd = 0; m_sc = 0; m_exp = 0;
        m_gq = 1; m_sg = 0; m_st = 0; m_ok = 0; m_bad = 0; m_go = 0;
    endtask

    task automatic m_step();
        bit start, first, pend, t;
        int nt, tgt;
        if (!rst_n) begin
            m_reset();
            return;
        end
        start = gs && !m_gq;
        first = m_st;
        pend  = m_pend >= 0;
        nt    = pend ? m_pend : m_tl;
        t     = tick && !pend;
        tgt   = first ? int'(sym) : m_exp;
        if (first) m_exp = sym;
        m_gq = gs; m_sg = 0; m_st = 0; m_ok = 0; m_bad = 0; m_pend = -1;
        case (m_ph)
            0, 4: if (start) begin
                m_ph = 1; m_sg = 1; m_sc = 0; m_rnd = 1; m_go = 0; nt = P;
            end
            1: if (t && nt == 1) begin
                nt = 0; m_st = 1; m_ph = 2; m_pend = A;
            end else if (t && nt > 0) nt--;
            2: if (av) begin
                if (int'(ans) == tgt) begin
                    m_ok = 1; m_sc = m_sc < 15 ? m_sc + 1 : 15;
                end else m_bad = 1;
                m_ph = 3; nt = R;
            end else if (t && nt == 1) begin
                m_bad = 1; nt = 0; m_ph = 3; m_pend = R;
            end else if (t && nt > 0) nt--;
            3: if (t && nt == 1) begin
                nt = 0;
                if (m_rnd == N) begin
                    m_ph = 4; m_go = 1;
                end else begin
                    m_rnd++; m_ph = 1; m_sg = 1; m_pend = P;
                end
            end else if (t && nt > 0) nt--;
            default: ;
        endcase
        m_tl = nt;
    endtask

    task automatic check_all();
        check("phase", phase, m_ph);
        check("timeLeft", time_left, m_tl);
        check("roundNum", round_num, m_rnd);
        check("score", score, m_sc);
        check("startGen", start_gen, m_sg);
        check("stopGen", stop_gen, m_st);
        check("answerSig", answer_sig, m_ph == 2);
        check("correct", correct, m_ok);
        check("wrong", wrong, m_bad);
        check("gameOver", game_over, m_go);
    endtask

    task automatic step(input bit t, input bit v);
        tick = t;
        av = v;
        @(posedge clk);
        m_step();
        #1 check_all();
        tick = 1'b0;
        av = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1, 0);
            step(0, 0);
        end
    endtask

    task automatic restart();
        gs = 1'b0;
        step(0, 0);
        gs = 1'b1;
        step(0, 0);
    endtask

    initial begin
        m_reset();
        repeat (3) step(0, 0);
        check("rst_phase", phase, 0);
        check("rst_gameOver", game_over, 0);
        rst_n = 1'b1;
        repeat (3) step(0, 0);
        check("held_no_start", start_gen, 0);
        restart();
        check("start_pulse", start_gen, 1);
        check("start_phase", phase, 1);
        check("start_time", time_left, 15);
        sym = 8'd37;
        ticks(14);
        check("show_no_stop", stop_gen, 0);
        step(1, 0);
        check("stop_pulse", stop_gen, 1);
        check("answer_phase", phase, 2);
        step(0, 0);
        check("answer_reload", time_left, 10);
        check("stop_once", stop_gen, 0);
        ans = 8'd37;
        step(0, 1);
        check("match_correct", correct, 1);
        check("match_score", score, 1);
        check("result_phase", phase, 3);
        ticks(2);
        check("round2_phase", phase, 1);
        check("round2_num", round_num, 2);
        ticks(15);
        step(0, 0);
        ans = 8'd36;
        step(0, 1);
        check("miss_wrong", wrong, 1);
        check("miss_score", score, 1);
        ticks(2);
        check("over_flag", game_over, 1);
        check("over_phase", phase, 4);
        restart();
        check("restart_score", score, 0);
        check("restart_round", round_num, 1);
        ticks(15);
        ticks(9);
        check("timeout_early", wrong, 0);
        step(1, 0);
        check("timeout_wrong", wrong, 1);
        ticks(2);
        ticks(15);
        ticks(9);
        ans = 8'd37;
        step(1, 1);
        check("race_correct", correct, 1);
        check("race_not_wrong", wrong, 0);
        ticks(2);
        restart();
        ticks(5);
        #3 rst_n = 1'b0;
        #1 m_reset();
        check("async_phase", phase, 0);
        check("async_time", time_left, 0);
        check("async_round", round_num, 0);
        check("async_start", start_gen, 0);
        repeat (2) step(0, 0);
        rst_n = 1'b1;
        ticks(20);
        check("post_rst_idle", phase, 0);
        repeat (15000) begin
            if ($urandom_range(0, 39) == 0) gs = ~gs;
            if (m_ph != 2 && $urandom_range(0, 7) == 0) sym = 8'($urandom_range(0, 255));
            ans = $urandom_range(0, 1) ? sym : 8'($urandom_range(0, 255));
            rst_n = $urandom_range(0, 2999) != 0;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
